mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller for the EX stage.
// Accepts one MDU request at a time, computes the 64-bit product or the
// quotient/remainder when the request is accepted, and then models the
// multi-cycle latency with a down-counter. HI/LO are written only when the
// counter reaches its terminal count, or straight away for MTHI/MTLO.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no operation in flight, new requests accepted
// MUL   | MULT/MULTU in flight, pending product waits for terminal count
// DIV   | DIV/DIVU in flight, pending quotient/remainder waits likewise
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_MDUop,
  input  logic [31:0] E_srcA,
  input  logic [31:0] E_srcB,
  input  logic        D_MDUuse,
  output logic        E_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic        E_stall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi_q, pend_lo_q;

  logic          op_mul, op_div, div_signed;
  logic [63:0]   prod_d;
  logic [31:0]   num_mag, den_mag, den_safe, quot_mag, rem_mag;
  logic [31:0]   div_hi_d, div_lo_d;
  logic          quot_neg, rem_neg;

  // Operation decode and the product / quotient / remainder of the current
  // operands. Signed division runs on magnitudes and fixes signs afterwards,
  // which keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  always_comb begin
    op_mul     = (E_MDUop == OP_MULT) || (E_MDUop == OP_MULTU);
    op_div     = (E_MDUop == OP_DIV)  || (E_MDUop == OP_DIVU);
    div_signed = (E_MDUop == OP_DIV);

    if (E_MDUop == OP_MULT)
      prod_d = $signed({{32{E_srcA[31]}}, E_srcA}) * $signed({{32{E_srcB[31]}}, E_srcB});
    else
      prod_d = {32'd0, E_srcA} * {32'd0, E_srcB};

    num_mag  = (div_signed && E_srcA[31]) ? (~E_srcA + 32'd1) : E_srcA;
    den_mag  = (div_signed && E_srcB[31]) ? (~E_srcB + 32'd1) : E_srcB;
    den_safe = (den_mag == 32'd0) ? 32'd1 : den_mag;
    quot_mag = num_mag / den_safe;
    rem_mag  = num_mag % den_safe;
    quot_neg = div_signed && (E_srcA[31] ^ E_srcB[31]);
    rem_neg  = div_signed && E_srcA[31];

    // A zero divisor leaves HI/LO untouched, so the pending value is the
    // current HI/LO; nothing else can write them while the divide is busy.
    if (E_srcB == 32'd0) begin
      div_hi_d = hi_q;
      div_lo_d = lo_q;
    end else begin
      div_hi_d = rem_neg  ? (~rem_mag  + 32'd1) : rem_mag;
      div_lo_d = quot_neg ? (~quot_mag + 32'd1) : quot_mag;
    end
  end

  // Hold request to the hazard unit; combinational so it also works in reset.
  always_comb begin
    E_stall = D_MDUuse && (busy_q || (E_start && (op_mul || op_div)));
  end

  // Sequencer: accept in IDLE, count down while busy, commit HI/LO at count 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_start) begin
            if (op_mul) begin
              pend_hi_q <= prod_d[63:32];
              pend_lo_q <= prod_d[31:0];
              cnt_q     <= CW'(MULT_CYC);
              state_q   <= MUL;
              busy_q    <= 1'b1;
            end else if (op_div) begin
              pend_hi_q <= div_hi_d;
              pend_lo_q <= div_lo_d;
              cnt_q     <= CW'(DIV_CYC);
              state_q   <= DIV;
              busy_q    <= 1'b1;
            end else if (E_MDUop == OP_MTHI) begin
              hi_q <= E_srcA;
            end else if (E_MDUop == OP_MTLO) begin
              lo_q <= E_srcA;
            end
          end
        end
        MUL, DIV: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign E_busy = busy_q;
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

endmodule
